aes_key_expander: RTL and testbench
===================================

// Module: aes_key_expander
// PURPOSE
//  Sequential AES key schedule for 128/192/256-bit keys, selected at run time. Expands
//  the cipher key one 32-bit word per cycle into an internal round-key store.
//  Serves any round key on request by round index, in forward (encrypt) or reverse
//  (decrypt) order. Sits between the key register file and the AES round datapath.
//  Replaces per-round combinational key generation.
// PARAMETERS
//  MAX_KEY_BITS  256  largest supported key: 128|192|256; sizes the store to 4*(MAX_KEY_BITS/32+7) words
// PORTS
//  clk          in   1    single clock; all logic on rising edge
//  rst_n        in   1    asynchronous active-low reset
//  start        in   1    pulse: sample key_in/key_size, begin expansion
//  key_size     in   2    00=128, 01=192, 10=256, 11=reserved
//  key_in       in   256  cipher key, MSB-aligned (128-bit key in [255:128])
//  busy         out  1    expansion in progress
//  ready        out  1    round-key store valid
//  rk_rd        in   1    round-key read request
//  rk_dec       in   1    1 = reverse order: physical round = Nr - rk_idx
//  rk_idx       in   4    logical round index 0..Nr
//  rk_out       out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
//  rk_valid     out  1    rk_out valid (1-cycle pulse)
//  err          out  1    1-cycle pulse on a rejected start or rejected read
// BEHAVIOUR
//  Reset: busy=0, ready=0, rk_out=0, rk_valid=0, err=0, FSM=IDLE, rcon=8'h01. Store contents undefined.
//  Derived values: Nk=4/6/8; Nr=Nk+6; Wtot=4*(Nr+1)=44/52/60.
//  FSM: IDLE -> LOAD -> EXPAND -> DONE. DONE -> LOAD on a new start.
//  Cycle 0: start sampled in IDLE or DONE. Next state is LOAD; busy=1 and ready=0 from cycle 1.
//  LOAD (cycle 1): write w[0..Nk-1] from key_in in one cycle. Set i=Nk, j=0 (j = i mod Nk), rcon=01.
//  EXPAND: one word per cycle, i = Nk..Wtot-1.
//    t = w[i-1].
//    If j==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon = xtime(rcon) (0x80 -> 0x1b).
//    Else if Nk==8 and j==4: t = SubWord(t).
//    Write w[i] = w[i-Nk] ^ t. Increment i; j wraps at Nk (no divider).
//  After writing w[Wtot-1], go to DONE with busy=0 and ready=1.
//    ready rises at cycle 2+Wtot-Nk: 42 (128), 48 (192), 54 (256).
//  SubWord uses 4 combinational S-box lanes (no start/finish handshake, zero latency).
//  Rejected start (err pulses, no state change):
//    key_size=11, or key size > MAX_KEY_BITS.
//    start while busy; expansion continues unaffected.
//  A valid start in DONE drops ready on the next cycle. Old keys are lost.
//  Read: rk_rd sampled with ready=1 and rk_idx<=Nr. Next cycle: rk_out = round key, rk_valid=1.
//    rk_out holds its value until the next accepted read.
//  Rejected read (err pulses, rk_valid=0, rk_out unchanged):
//    rk_rd with ready=0, or rk_idx>Nr.
//  Back-to-back reads are allowed, one per cycle with full throughput.
//  start and rk_rd in the same cycle while in DONE: the read is served from the old table, then ready drops.
//  rst_n asserted mid-expansion: immediate return to reset values; a new start is required.
// TESTING
//  128-bit: key 2b7e1516_28aed2a6_abf71588_09cf4f3c, then read idx 10 -> d014f9a8_c9ee2589_e13f0cc8_b6630ca6; ready at cycle 42.
//  192-bit: key 8e73b0f7..522c6b7b, then read idx 12 -> e98ba06f_448c773c_8ecc7204_01002202; ready at cycle 48.
//  256-bit: key 603deb10..0914dff4, then read idx 14 -> fe4890d1_e6188d0b_046df344_706c631e; read rk_dec=1, idx 0 -> same value.
//  rk_rd during busy, or rk_idx=11 with 128-bit key -> err pulse, rk_valid=0; key_size=11 -> err, FSM stays IDLE.
//  start again during EXPAND -> err pulse, ready timing unchanged. rst_n low at cycle 20 -> all outputs 0, ready stays 0.
//  Back-to-back reads idx 0..10 -> 11 consecutive rk_valid cycles; idx 0 returns key_in[255:128].

Source files
------------

// File: rtl/aes_key_expander_if.sv
// Key-schedule control and round-key read bus between the AES key register file,
// the round datapath and aes_key_expander.
interface aes_key_expander_if;
  logic         start;
  logic [1:0]   key_size;
  logic [255:0] key_in;
  logic         busy;
  logic         ready;
  logic         rk_rd;
  logic         rk_dec;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic         err;

  modport master (
    output start, key_size, key_in, rk_rd, rk_dec, rk_idx,
    input  busy, ready, rk_out, rk_valid, err
  );

  modport slave (
    input  start, key_size, key_in, rk_rd, rk_dec, rk_idx,
    output busy, ready, rk_out, rk_valid, err
  );
endinterface

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule: one expanded word per cycle into a
// round-key store, then random-access round-key reads in forward or reverse order.
module aes_key_expander #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  aes_key_expander_if.slave   bus
);
  localparam int MAX_NK = MAX_KEY_BITS / 32;
  localparam int WORDS  = 4 * (MAX_NK + 7);
  localparam int AW     = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t         state_reg, state_next;
  logic [255:0]   key_reg;
  logic [1:0]     ks_reg;
  logic [AW-1:0]  i_reg;
  logic [2:0]     j_reg;
  logic [7:0]     rcon_reg;
  logic [127:0]   rk_out_reg;
  logic           rk_valid_reg;
  logic           err_reg;
  logic [31:0]    w [WORDS];

  logic [3:0]     nk, nr;
  logic [AW-1:0]  last_idx;
  logic           busy, ready;
  logic           size_ok, start_ok, start_rej;
  logic           rd_ok, rd_rej;
  logic [3:0]     phys;
  logic [AW-1:0]  rd_base;
  logic [31:0]    prev_word, back_word, sub_in, sub_out, t_word, new_word;

  assign nk       = 4'd4 + {1'b0, ks_reg, 1'b0};
  assign nr       = nk + 4'd6;
  assign last_idx = AW'({nr, 2'b11});
  assign busy     = (state_reg == LOAD) || (state_reg == EXPAND);
  assign ready    = (state_reg == DONE);

  assign size_ok   = (bus.key_size != 2'b11) &&
                     ((128 + 64 * int'(bus.key_size)) <= MAX_KEY_BITS);
  assign start_ok  = bus.start && !busy && size_ok;
  assign start_rej = bus.start && !start_ok;

  // Reads use the geometry of the table currently held, even if a restart is accepted alongside.
  assign rd_ok   = bus.rk_rd && ready && (bus.rk_idx <= nr);
  assign rd_rej  = bus.rk_rd && !rd_ok;
  assign phys    = bus.rk_dec ? (nr - bus.rk_idx) : bus.rk_idx;
  assign rd_base = AW'({phys, 2'b00});

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_out[8*gi +: 8] = sbox(sub_in[8*gi +: 8]);
    end
  endgenerate

  always_comb begin
    prev_word = w[i_reg - AW'(1)];
    back_word = w[i_reg - AW'(nk)];
    sub_in    = (j_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    if (j_reg == 3'd0)
      t_word = sub_out ^ {rcon_reg, 24'h000000};
    else if (nk == 4'd8 && j_reg == 3'd4)
      t_word = sub_out;
    else
      t_word = prev_word;
    new_word = back_word ^ t_word;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = LOAD;
      LOAD:    state_next = EXPAND;
      EXPAND:  if (i_reg == last_idx) state_next = DONE;
      DONE:    if (start_ok) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      key_reg      <= '0;
      ks_reg       <= 2'd0;
      i_reg        <= '0;
      j_reg        <= 3'd0;
      rcon_reg     <= 8'h01;
      rk_out_reg   <= '0;
      rk_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rk_valid_reg <= rd_ok;
      err_reg      <= start_rej || rd_rej;
      if (rd_ok)
        rk_out_reg <= {w[rd_base], w[rd_base + AW'(1)], w[rd_base + AW'(2)], w[rd_base + AW'(3)]};
      if (start_ok) begin
        key_reg <= bus.key_in;
        ks_reg  <= bus.key_size;
      end
      if (state_reg == LOAD) begin
        i_reg    <= AW'(nk);
        j_reg    <= 3'd0;
        rcon_reg <= 8'h01;
      end else if (state_reg == EXPAND) begin
        i_reg <= i_reg + AW'(1);
        j_reg <= ({1'b0, j_reg} == nk - 4'd1) ? 3'd0 : j_reg + 3'd1;
        if (j_reg == 3'd0)
          rcon_reg <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
      end
    end
  end

  // Store has no reset: its contents are only meaningful once ready is high.
  always_ff @(posedge clk) begin
    if (state_reg == LOAD) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(nk) && k < WORDS)
          w[k] <= key_reg[255 - 32*k -: 32];
      end
    end else if (state_reg == EXPAND) begin
      w[i_reg] <= new_word;
    end
  end

  assign bus.busy     = busy;
  assign bus.ready    = ready;
  assign bus.rk_out   = rk_out_reg;
  assign bus.rk_valid = rk_valid_reg;
  assign bus.err      = err_reg;
endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: FIPS-197 known answers, corner sequences and random
// keys checked against a straightforward key-schedule model.
module tb_aes_key_expander;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_key_expander_if bus();
  aes_key_expander #(.MAX_KEY_BITS(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]   ks;
    logic [255:0] key;
    logic [3:0]   idx;
    logic         dec;
    logic [127:0] exp_rk;
    int           exp_cyc;
  } kat_t;
  kat_t kat [4];

  logic [7:0]   sb [256];
  logic [31:0]  mw [60];
  int           m_nk, m_nr;
  logic [127:0] last_rk;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  function automatic kat_t mk(input logic [1:0] ks, input logic [255:0] key, input logic [3:0] idx,
                              input logic dec, input logic [127:0] rk, input int cyc);
    kat_t k;
    k.ks = ks; k.key = key; k.idx = idx; k.dec = dec; k.exp_rk = rk; k.exp_cyc = cyc;
    return k;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Build the S-box by brute-force inverse search and the bitwise affine equation.
  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic model_expand(input logic [1:0] ks, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    m_nk = 4 + 2 * int'(ks);
    m_nr = m_nk + 6;
    for (int i = 0; i < m_nk; i++) mw[i] = key[255 - 32*i -: 32];
    for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
      t = mw[i-1];
      if (i % m_nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (m_nk == 8 && i % m_nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-m_nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rk_of(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] ks, input logic [255:0] key);
    bus.start = 1'b1; bus.key_size = ks; bus.key_in = key;
    tick();
    bus.start = 1'b0;
    $display("start size=%0d key=%h err=%0b", ks, key, bus.err);
  endtask

  task automatic wait_ready(input int c0, output int cyc);
    cyc = c0;
    while (bus.ready !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_read(input string name, input logic [3:0] idx, input logic dec,
                         input logic ok, input logic [127:0] exp);
    bus.rk_rd = 1'b1; bus.rk_idx = idx; bus.rk_dec = dec;
    tick();
    bus.rk_rd = 1'b0;
    $display("read %s idx=%0d dec=%0b valid=%0b err=%0b rk=%h", name, idx, dec,
             bus.rk_valid, bus.err, bus.rk_out);
    if (ok) last_rk = exp;
    chk({name, ".valid"}, 128'(bus.rk_valid), 128'(ok));
    chk({name, ".err"},   128'(bus.err),      128'(!ok));
    chk({name, ".rk"},    bus.rk_out,         last_rk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int phys;
    logic [1:0]   ks;
    logic [255:0] key;
    logic [3:0]   idx;
    logic         dec;
    logic [127:0] old_rk [11];

    kat[0] = mk(2'd0, K128, 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 42);
    kat[1] = mk(2'd1, K192, 4'd12, 1'b0, 128'he98ba06f448c773c8ecc720401002202, 48);
    kat[2] = mk(2'd2, K256, 4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e, 54);
    kat[3] = mk(2'd2, K256, 4'd0,  1'b1, 128'hfe4890d1e6188d0b046df344706c631e, 54);
    build_sbox();

    bus.start = 1'b0; bus.key_size = 2'd0; bus.key_in = '0;
    bus.rk_rd = 1'b0; bus.rk_dec = 1'b0; bus.rk_idx = 4'd0;
    last_rk = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    chk("reset.busy",     128'(bus.busy),     128'(0));
    chk("reset.ready",    128'(bus.ready),    128'(0));
    chk("reset.rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("reset.err",      128'(bus.err),      128'(0));
    chk("reset.rk_out",   bus.rk_out,         128'(0));
    rst_n = 1'b1;
    tick();

    // Reserved key size is refused and the FSM stays idle.
    do_start(2'd3, K256);
    chk("rsv.err",  128'(bus.err),  128'(1));
    chk("rsv.busy", 128'(bus.busy), 128'(0));
    tick();
    chk("rsv.idle", 128'(bus.busy | bus.ready), 128'(0));
    do_read("idle_rd", 4'd0, 1'b0, 1'b0, '0);

    foreach (kat[v]) begin
      do_start(kat[v].ks, kat[v].key);
      chk($sformatf("kat%0d.busy1", v), 128'({bus.busy, bus.ready}), 128'(2'b10));
      wait_ready(1, cyc);
      chk($sformatf("kat%0d.ready_cyc", v), 128'(cyc), 128'(kat[v].exp_cyc));
      do_read($sformatf("kat%0d", v), kat[v].idx, kat[v].dec, 1'b1, kat[v].exp_rk);
    end

    // Read while busy and restart during EXPAND are refused; timing and table unaffected.
    model_expand(2'd0, K128);
    do_start(2'd0, K128);
    do_read("busy_rd", 4'd0, 1'b0, 1'b0, '0);
    bus.start = 1'b1; bus.key_size = 2'd0; bus.key_in = '1;
    tick();
    bus.start = 1'b0;
    chk("busy_start.err", 128'(bus.err), 128'(1));
    wait_ready(3, cyc);
    chk("busy_start.ready_cyc", 128'(cyc), 128'(42));
    for (int r = 0; r <= 10; r++) begin
      old_rk[r] = (r == 0) ? K128[255:128] : rk_of(r);
      do_read($sformatf("b2b%0d", r), 4'(r), 1'b0, 1'b1, old_rk[r]);
    end
    do_read("idx11", 4'd11, 1'b0, 1'b0, '0);
    do_read("idx15dec", 4'd15, 1'b1, 1'b0, '0);

    // Simultaneous start and read in DONE: read served from the old table.
    bus.start = 1'b1; bus.key_size = 2'd1; bus.key_in = K192;
    bus.rk_rd = 1'b1; bus.rk_idx = 4'd5; bus.rk_dec = 1'b0;
    tick();
    bus.start = 1'b0; bus.rk_rd = 1'b0;
    $display("read start+rd idx=5 valid=%0b err=%0b rk=%h", bus.rk_valid, bus.err, bus.rk_out);
    last_rk = old_rk[5];
    chk("both.valid", 128'(bus.rk_valid), 128'(1));
    chk("both.rk",    bus.rk_out,         old_rk[5]);
    chk("both.ready", 128'(bus.ready),    128'(0));
    model_expand(2'd1, K192);
    wait_ready(1, cyc);
    chk("both.ready_cyc", 128'(cyc), 128'(48));
    do_read("both_new", 4'd3, 1'b1, 1'b1, rk_of(m_nr - 3));

    // Reset in the middle of an expansion.
    do_start(2'd2, K256);
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst.outs", 128'({bus.busy, bus.ready, bus.rk_valid, bus.err}), 128'(0));
    chk("midrst.rk_out", bus.rk_out, 128'(0));
    last_rk = '0;
    tick();
    rst_n = 1'b1;
    cyc = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (bus.ready) cyc++;
    end
    chk("midrst.ready_stays0", 128'(cyc), 128'(0));

    // Random keys and reads against the model.
    for (int n = 0; n < 6; n++) begin
      ks  = 2'($urandom_range(0, 2));
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model_expand(ks, key);
      do_start(ks, key);
      wait_ready(1, cyc);
      chk($sformatf("rnd%0d.ready_cyc", n), 128'(cyc), 128'(2 + 4 * (m_nr + 1) - m_nk));
      for (int q = 0; q < 8; q++) begin
        idx  = 4'($urandom_range(0, 15));
        dec  = 1'($urandom);
        phys = dec ? (m_nr - int'(idx)) : int'(idx);
        do_read($sformatf("rnd%0d_%0d", n, q), idx, dec, int'(idx) <= m_nr,
                (int'(idx) <= m_nr) ? rk_of(phys) : 128'(0));
      end
    end

    // Reserved size in DONE: refused, table stays ready.
    do_start(2'd3, K128);
    chk("rsv_done.err",   128'(bus.err),   128'(1));
    chk("rsv_done.ready", 128'(bus.ready), 128'(1));
    do_read("rsv_done_rd", 4'd0, 1'b0, 1'b1, rk_of(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
